// File: rtl/hybrid_ctrl_pkg.sv
// Types and widths shared between the dead-time insertion stage and its monitor.
package hybrid_ctrl_pkg;

  // Shared with the insertion stage so deadtime and min_dt widths always match.
  localparam int unsigned DT_CNT_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H_ON,
    S_L_ON,
    S_GAP_HL,
    S_GAP_LH,
    S_OVERLAP
  } dt_mon_state_t;

endpackage : hybrid_ctrl_pkg

// File: rtl/dt_sat_counter.sv
// Saturating up-counter used to measure gate gaps; load forces the count to 1.
import hybrid_ctrl_pkg::*;

module dt_sat_counter #(
  parameter int unsigned CNT_W = DT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CNT_W'(1);
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : dt_sat_counter

// File: rtl/dead_time_monitor.sv
// Measures the dead time between complementary gate commands in each direction
// and flags shoot-through and too-short gaps with sticky faults.
import hybrid_ctrl_pkg::*;

module dead_time_monitor #(
  parameter int unsigned CNT_W = DT_CNT_W
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_gate_h,
  input  logic             i_gate_l,
  input  logic [CNT_W-1:0] i_min_dt,
  input  logic             i_fault_clear,
  output logic [CNT_W-1:0] o_dt_hl,
  output logic [CNT_W-1:0] o_dt_lh,
  output logic             o_dt_valid,
  output logic             o_dt_dir,
  output logic             o_shoot_through,
  output logic             o_dt_violation
);

  dt_mon_state_t    state_q, state_d;
  logic             s_h_q, s_l_q;
  logic             both_hi, both_lo;
  logic             cnt_load, cnt_inc;
  logic [CNT_W-1:0] count;
  logic             cap_hl, cap_lh;
  logic [CNT_W-1:0] cap_val;

  logic [CNT_W-1:0] dt_hl_q, dt_hl_d;
  logic [CNT_W-1:0] dt_lh_q, dt_lh_d;
  logic             valid_q, valid_d;
  logic             dir_q, dir_d;
  logic             shoot_q, shoot_d;
  logic             viol_q, viol_d;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      s_h_q <= 1'b0;
      s_l_q <= 1'b0;
    end else begin
      s_h_q <= i_gate_h;
      s_l_q <= i_gate_l;
    end
  end

  assign both_hi = s_h_q & s_l_q;
  assign both_lo = ~s_h_q & ~s_l_q;

  dt_sat_counter #(
    .CNT_W (CNT_W)
  ) u_gap_cnt (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .load_i  (cnt_load),
    .inc_i   (cnt_inc),
    .count_o (count)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    cap_hl   = 1'b0;
    cap_lh   = 1'b0;
    cap_val  = '0;
    // Overlap overrides every state, including an open gap.
    if (both_hi) begin
      state_d = S_OVERLAP;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (s_h_q)      state_d = S_H_ON;
          else if (s_l_q) state_d = S_L_ON;
        end
        S_H_ON: begin
          if (both_lo) begin
            state_d  = S_GAP_HL;
            cnt_load = 1'b1;
          end else if (s_l_q) begin
            state_d = S_L_ON;
            cap_hl  = 1'b1;
          end
        end
        S_L_ON: begin
          if (both_lo) begin
            state_d  = S_GAP_LH;
            cnt_load = 1'b1;
          end else if (s_h_q) begin
            state_d = S_H_ON;
            cap_lh  = 1'b1;
          end
        end
        S_GAP_HL: begin
          if (both_lo) begin
            cnt_inc = 1'b1;
          end else if (s_l_q) begin
            state_d = S_L_ON;
            cap_hl  = 1'b1;
            cap_val = count;
          end else begin
            state_d = S_H_ON;
          end
        end
        S_GAP_LH: begin
          if (both_lo) begin
            cnt_inc = 1'b1;
          end else if (s_h_q) begin
            state_d = S_H_ON;
            cap_lh  = 1'b1;
            cap_val = count;
          end else begin
            state_d = S_L_ON;
          end
        end
        S_OVERLAP: begin
          if (s_h_q)      state_d = S_H_ON;
          else if (s_l_q) state_d = S_L_ON;
          else            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dt_hl_d = dt_hl_q;
    dt_lh_d = dt_lh_q;
    valid_d = 1'b0;
    dir_d   = dir_q;
    shoot_d = i_fault_clear ? 1'b0 : shoot_q;
    viol_d  = i_fault_clear ? 1'b0 : viol_q;
    if (cap_hl) begin
      dt_hl_d = cap_val;
      dir_d   = 1'b0;
      valid_d = 1'b1;
    end
    if (cap_lh) begin
      dt_lh_d = cap_val;
      dir_d   = 1'b1;
      valid_d = 1'b1;
    end
    // Fault events take precedence over a simultaneous clear.
    if ((cap_hl || cap_lh) && (i_min_dt != '0) && (cap_val < i_min_dt)) begin
      viol_d = 1'b1;
    end
    if (both_hi) begin
      shoot_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      dt_hl_q <= '0;
      dt_lh_q <= '0;
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
      shoot_q <= 1'b0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dt_hl_q <= dt_hl_d;
      dt_lh_q <= dt_lh_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      shoot_q <= shoot_d;
      viol_q  <= viol_d;
    end
  end

  assign o_dt_hl         = dt_hl_q;
  assign o_dt_lh         = dt_lh_q;
  assign o_dt_valid      = valid_q;
  assign o_dt_dir        = dir_q;
  assign o_shoot_through = shoot_q;
  assign o_dt_violation  = viol_q;

endmodule : dead_time_monitor

// File: tb/tb_dead_time_monitor.sv
// Directed bench for dead_time_monitor: one task per scenario, inline checks.
module tb_dead_time_monitor;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         gate_h;
  logic         gate_l;
  logic [W-1:0] min_dt;
  logic         fault_clear;
  logic [W-1:0] dt_hl;
  logic [W-1:0] dt_lh;
  logic         dt_valid;
  logic         dt_dir;
  logic         shoot;
  logic         viol;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  dead_time_monitor #(
    .CNT_W (W)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_gate_h        (gate_h),
    .i_gate_l        (gate_l),
    .i_min_dt        (min_dt),
    .i_fault_clear   (fault_clear),
    .o_dt_hl         (dt_hl),
    .o_dt_lh         (dt_lh),
    .o_dt_valid      (dt_valid),
    .o_dt_dir        (dt_dir),
    .o_shoot_through (shoot),
    .o_dt_violation  (viol)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later; counts valid pulses.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (dt_valid === 1'b1) vcount++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; gate_h = 1'b0; gate_l = 1'b0; min_dt = '0; fault_clear = 1'b0;
    tick(3);
    checks++;
    if ({dt_hl, dt_lh, dt_valid, dt_dir, shoot, viol} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got hl=%0d lh=%0d v=%b d=%b st=%b vi=%b want all 0",
               dt_hl, dt_lh, dt_valid, dt_dir, shoot, viol);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_hl_basic();
    min_dt = 10'd3;
    gate_h = 1'b1; gate_l = 1'b0;
    tick(20);
    gate_h = 1'b0;
    tick(5);
    gate_l = 1'b1;
    vcount = 0;
    tick(1);
    checks++;
    if (dt_valid !== 1'b0) begin
      errors++; $display("FAIL hl_valid_edge1 got %b want 0", dt_valid);
    end
    tick(1);
    checks++;
    if (dt_valid !== 1'b1 || dt_hl !== 10'd5 || dt_dir !== 1'b0 || viol !== 1'b0) begin
      errors++;
      $display("FAIL hl_capture got v=%b hl=%0d dir=%b viol=%b want v=1 hl=5 dir=0 viol=0",
               dt_valid, dt_hl, dt_dir, viol);
    end
    tick(3);
    checks++;
    if (vcount != 1) begin
      errors++; $display("FAIL hl_single_pulse got %0d pulses want 1", vcount);
    end
  endtask

  task automatic test_lh_violation();
    min_dt = 10'd8;
    tick(5);
    gate_l = 1'b0;
    tick(6);
    gate_h = 1'b1;
    tick(2);
    checks++;
    if (dt_valid !== 1'b1 || dt_lh !== 10'd6 || dt_dir !== 1'b1 || viol !== 1'b1) begin
      errors++;
      $display("FAIL lh_capture got v=%b lh=%0d dir=%b viol=%b want v=1 lh=6 dir=1 viol=1",
               dt_valid, dt_lh, dt_dir, viol);
    end
    tick(100);
    checks++;
    if (viol !== 1'b1 || dt_lh !== 10'd6) begin
      errors++; $display("FAIL viol_sticky got viol=%b lh=%0d want 1/6", viol, dt_lh);
    end
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    checks++;
    if (viol !== 1'b0) begin
      errors++; $display("FAIL viol_clear got %b want 0", viol);
    end
  endtask

  task automatic test_shoot_through();
    min_dt = '0;
    tick(3);
    vcount = 0;
    gate_h = 1'b1; gate_l = 1'b1; fault_clear = 1'b1;
    tick(1);
    gate_l = 1'b0; fault_clear = 1'b0;
    tick(5);
    checks++;
    if (shoot !== 1'b1 || vcount != 0) begin
      errors++; $display("FAIL shoot_set got st=%b pulses=%0d want st=1 pulses=0", shoot, vcount);
    end
    gate_h = 1'b0;
    tick(3);
    gate_l = 1'b1;
    tick(2);
    checks++;
    if (dt_valid !== 1'b1 || dt_hl !== 10'd3 || shoot !== 1'b1 || viol !== 1'b0) begin
      errors++;
      $display("FAIL shoot_resume got v=%b hl=%0d st=%b viol=%b want v=1 hl=3 st=1 viol=0",
               dt_valid, dt_hl, shoot, viol);
    end
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    checks++;
    if (shoot !== 1'b0) begin
      errors++; $display("FAIL shoot_clear got %b want 0", shoot);
    end
  endtask

  task automatic test_saturation();
    gate_l = 1'b0;
    tick(2);
    gate_h = 1'b1;
    tick(5);
    gate_h = 1'b0;
    tick(1500);
    gate_l = 1'b1;
    tick(2);
    checks++;
    if (dt_valid !== 1'b1 || dt_hl !== 10'd1023 || dt_dir !== 1'b0) begin
      errors++;
      $display("FAIL saturate got v=%b hl=%0d dir=%b want v=1 hl=1023 dir=0",
               dt_valid, dt_hl, dt_dir);
    end
  endtask

  task automatic test_abort_and_direct();
    gate_l = 1'b0;
    tick(2);
    gate_h = 1'b1;
    tick(5);
    vcount = 0;
    gate_h = 1'b0;
    tick(4);
    gate_h = 1'b1;
    tick(6);
    checks++;
    if (vcount != 0 || dt_hl !== 10'd1023) begin
      errors++; $display("FAIL abort got pulses=%0d hl=%0d want 0/1023", vcount, dt_hl);
    end
    min_dt = 10'd2;
    gate_h = 1'b0; gate_l = 1'b1;
    tick(2);
    checks++;
    if (dt_valid !== 1'b1 || dt_hl !== 10'd0 || dt_dir !== 1'b0 || viol !== 1'b1) begin
      errors++;
      $display("FAIL direct_switch got v=%b hl=%0d dir=%b viol=%b want v=1 hl=0 dir=0 viol=1",
               dt_valid, dt_hl, dt_dir, viol);
    end
  endtask

  task automatic test_reset_mid_gap();
    tick(3);
    gate_l = 1'b0;
    tick(5);
    rst = 1'b1;
    #1;
    checks++;
    if ({dt_hl, dt_lh, dt_valid, dt_dir, shoot, viol} !== '0) begin
      errors++;
      $display("FAIL async_reset got hl=%0d lh=%0d v=%b d=%b st=%b vi=%b want all 0",
               dt_hl, dt_lh, dt_valid, dt_dir, shoot, viol);
    end
    tick(2);
    rst = 1'b0;
    tick(3);
    vcount = 0;
    gate_l = 1'b1;
    tick(4);
    checks++;
    if (vcount != 0 || dt_hl !== 10'd0 || dt_lh !== 10'd0) begin
      errors++;
      $display("FAIL post_reset_no_meas got pulses=%0d hl=%0d lh=%0d want 0/0/0",
               vcount, dt_hl, dt_lh);
    end
    gate_l = 1'b0;
    tick(4);
    gate_h = 1'b1;
    tick(2);
    checks++;
    if (dt_valid !== 1'b1 || dt_lh !== 10'd4 || dt_dir !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_measure got v=%b lh=%0d dir=%b want v=1 lh=4 dir=1",
               dt_valid, dt_lh, dt_dir);
    end
  endtask

  initial begin
    test_reset();
    test_hl_basic();
    test_lh_violation();
    test_shoot_through();
    test_saturation();
    test_abort_and_direct();
    test_reset_mid_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dead_time_monitor

// File: doc/dead_time_monitor.md
Name: dead_time_monitor

Overview:
- Measures and checks the dead time actually present on a complementary gate pair (high-side/low-side) after dead-time insertion.
- Sits downstream of the dead-time insertion stage, ahead of the gate-driver pins. It is the checking end of that path.
- Reports the measured gap for each commutation direction. Raises sticky faults on shoot-through (both gates on) and on a gap shorter than a programmed minimum.

Parameters:
- CNT_W, 10, width of the gap counter, the measured-value outputs and i_min_dt.

Ports:
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_gate_h  in  1  high-side gate command, synchronous to i_clock.
- i_gate_l  in  1  low-side gate command, synchronous to i_clock.
- i_min_dt  in  CNT_W  minimum allowed gap in clock cycles, sampled when a gap closes.
- i_fault_clear  in  1  one-cycle pulse; clears both sticky faults.
- o_dt_hl  out  CNT_W  last measured gap, H falling to L rising.
- o_dt_lh  out  CNT_W  last measured gap, L falling to H rising.
- o_dt_valid  out  1  one-cycle pulse when o_dt_hl or o_dt_lh updates.
- o_dt_dir  out  1  direction of last update: 0 = HL, 1 = LH.
- o_shoot_through  out  1  sticky: both gates seen high.
- o_dt_violation  out  1  sticky: a measured gap was below i_min_dt.

Behaviour:
- Reset:
  - All outputs go to 0 immediately.
  - Sample registers go to 0, counter goes to 0, FSM goes to S_IDLE.
- Input stage:
  - i_gate_h and i_gate_l are registered once (s_h, s_l).
  - The FSM acts on s_h and s_l only.
- FSM states: S_IDLE, S_H_ON, S_L_ON, S_GAP_HL, S_GAP_LH, S_OVERLAP.
- Overlap (highest priority, from any state):
  - s_h=1 and s_l=1 → go to S_OVERLAP and set o_shoot_through.
  - Stay in S_OVERLAP while both are high.
  - On exit: exactly one high → S_H_ON or S_L_ON; both low → S_IDLE. No measurement is made on exit.
- S_IDLE:
  - s_h only → S_H_ON; s_l only → S_L_ON.
  - Both low → stay; no measurement, because the preceding edge is unknown.
- S_H_ON:
  - Both low → S_GAP_HL, counter loaded with 1.
  - s_l only (no gap sample) → S_L_ON; capture o_dt_hl=0, pulse valid, apply the violation check.
- S_L_ON: mirror of S_H_ON, going to S_GAP_LH and o_dt_lh.
- S_GAP_HL:
  - Both low → counter increments, saturating at 2^CNT_W-1 (no wrap).
  - s_l only → capture the counter into o_dt_hl, o_dt_dir=0, o_dt_valid=1 for one cycle, go to S_L_ON.
  - s_h re-rises → abort: no capture, no valid, go to S_H_ON (pulse-skipping case).
- S_GAP_LH: mirror of S_GAP_HL.
- Measured value = number of registered both-low samples in the gap. A gap of N cycles at the inputs reads N.
- Latency: o_dt_valid is asserted 2 rising edges after the closing input edge. Measured outputs hold their value until the next capture.
- Violation check:
  - At capture, if the captured value < i_min_dt, set o_dt_violation in the same cycle as the valid pulse.
  - i_min_dt=0 disables the check.
- Fault clear:
  - i_fault_clear clears both stickies on the next edge.
  - A fault event in the same cycle wins, so the flag stays 1.
- Reset mid-gap: the measurement is discarded. After release, nothing is measured until a one-gate-high state is seen.

Decomposition:
- Shared package (hybrid_ctrl_pkg):
  - FSM state typedef dt_mon_state_t.
  - Default constant DT_CNT_W=10, shared with the dead-time insertion stage so the deadtime and min_dt widths match.
- One sub-module, dt_sat_counter:
  - CNT_W-wide saturating up-counter.
  - Inputs: load-to-1, increment, async reset.
  - Output: count.

Test Plan:
- Reset, min_dt=3; H=1,L=0 for 20 cycles, both 0 for 5, then L=1 → o_dt_hl=5, o_dt_dir=0, o_dt_valid a single pulse 2 edges after the L rise, o_dt_violation=0.
- min_dt=8; L on, 6-cycle gap, H on → o_dt_lh=6, o_dt_violation=1 and still 1 after 100 cycles; i_fault_clear pulse → 0 next edge.
- From H on, drive H=L=1 for 1 cycle with i_fault_clear asserted the same cycle → o_shoot_through=1 and stays; no o_dt_valid; FSM resumes on a one-gate-high state.
- H on, gap of 1500 cycles, L on → o_dt_hl=1023 (saturated), no wrap.
- H on, both low 4 cycles, H re-rises → no o_dt_valid, o_dt_hl unchanged; a direct H→L switch with no gap → o_dt_hl=0, valid pulse, violation if min_dt>0.
- Assert i_reset during a 10-cycle gap → all outputs 0 asynchronously; after release with both low, closing edge L=1 → no valid pulse.
